// File: rtl/alu_pkg.sv
// alu_pkg: ALU control encodings, ALUOp values, R-type opcodes and issue FSM states
package alu_pkg;
  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_PASSB = 4'b0111;
  localparam logic [3:0] C_NOR = 4'b1100;
  localparam logic [1:0] C_MOVZ_HI = 2'b10;
  localparam logic [3:0] C_IDLE = 4'b1111;
  localparam logic [1:0] AOP_MEM = 2'b00;
  localparam logic [1:0] AOP_CBZ = 2'b01;
  localparam logic [1:0] AOP_R = 2'b10;
  localparam logic [1:0] AOP_MOVZ = 2'b11;
  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: request/response handshake bundle between a requester and alu_issue
interface alu_issue_if;
  logic req_valid;
  logic req_ready;
  logic [1:0] req_aluop;
  logic [10:0] req_opcode;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic rsp_valid;
  logic rsp_ready;
  logic [63:0] rsp_result;
  logic rsp_zero;
  logic rsp_illegal;
  modport master (output req_valid, req_aluop, req_opcode, req_a, req_b, rsp_ready,
                  input req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal);
  modport slave (input req_valid, req_aluop, req_opcode, req_a, req_b, rsp_ready,
                 output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_illegal);
endinterface

// File: rtl/alu_dec.sv
// alu_dec: combinational ALUOp/opcode to ALUControl decoder with illegal flag
module alu_dec
  import alu_pkg::*;
(
  input logic [1:0] aluop,
  input logic [10:0] opcode,
  output logic [3:0] ctrl,
  output logic illegal
);
  logic [3:0] rtype;
  assign rtype = opcode == OP_ADD ? C_ADD :
                 opcode == OP_SUB ? C_SUB :
                 opcode == OP_AND ? C_AND :
                 opcode == OP_ORR ? C_OR : C_IDLE;
  assign ctrl = aluop == AOP_MEM ? C_ADD :
                aluop == AOP_CBZ ? C_PASSB :
                aluop == AOP_MOVZ ? {C_MOVZ_HI, opcode[1:0]} : rtype;
  assign illegal = aluop == AOP_R && rtype == C_IDLE;
endmodule

// File: rtl/alu_issue.sv
// alu_issue: accepts one ALU request, drives the external ALU for one cycle, holds the response
module alu_issue
  import alu_pkg::*;
(
  input logic clk,
  input logic reset,
  alu_issue_if.slave bus,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [3:0] ALUControl,
  input logic [63:0] alu_result,
  input logic alu_zero,
  output logic [15:0] op_count
);
  state_t state, state_d;
  logic [63:0] a_q, b_q;
  logic [3:0] code_q, ctrl;
  logic illegal, accept;
  alu_dec u_dec (.aluop(bus.req_aluop), .opcode(bus.req_opcode), .ctrl(ctrl), .illegal(illegal));
  assign accept = state == S_IDLE && bus.req_valid;
  assign bus.req_ready = state == S_IDLE;
  assign bus.rsp_valid = state == S_RESP;
  assign alu_a = state == S_EXEC ? a_q : '0;
  assign alu_b = state == S_EXEC ? b_q : '0;
  assign ALUControl = state == S_EXEC ? code_q : C_IDLE;
  always_comb begin
    state_d = state;
    state_d = state == S_IDLE ? (bus.req_valid ? (illegal ? S_RESP : S_EXEC) : S_IDLE) :
              state == S_EXEC ? S_RESP :
              bus.rsp_ready ? S_IDLE : S_RESP;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      a_q <= '0;
      b_q <= '0;
      code_q <= C_IDLE;
      bus.rsp_result <= '0;
      bus.rsp_zero <= 1'b0;
      bus.rsp_illegal <= 1'b0;
      op_count <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        a_q <= bus.req_a;
        b_q <= bus.req_b;
        code_q <= ctrl;
        bus.rsp_result <= '0;
        bus.rsp_zero <= 1'b0;
        bus.rsp_illegal <= illegal;
      end
      if (state == S_EXEC) begin
        bus.rsp_result <= alu_result;
        bus.rsp_zero <= alu_zero;
      end
      if (state == S_RESP && bus.rsp_ready && !bus.rsp_illegal && op_count != 16'hFFFF)
        op_count <= op_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed vectors against alu_issue with a behavioural ALU attached
module tb_alu_issue;
  logic clk = 1'b0;
  logic reset;
  logic [63:0] alu_a, alu_b, alu_result;
  logic [3:0] ALUControl;
  logic alu_zero;
  logic [15:0] op_count;
  int errs = 0;
  int checks = 0;
  alu_issue_if bus ();
  alu_issue dut (.clk(clk), .reset(reset), .bus(bus), .alu_a(alu_a), .alu_b(alu_b),
                 .ALUControl(ALUControl), .alu_result(alu_result), .alu_zero(alu_zero),
                 .op_count(op_count));
  always #5 clk = ~clk;
  always_comb begin
    alu_result = '0;
    alu_result = ALUControl == 4'b0000 ? alu_a & alu_b :
                 ALUControl == 4'b0001 ? alu_a | alu_b :
                 ALUControl == 4'b0010 ? alu_a + alu_b :
                 ALUControl == 4'b0110 ? alu_a - alu_b :
                 ALUControl == 4'b0111 ? alu_b :
                 ALUControl == 4'b1100 ? ~(alu_a | alu_b) :
                 ALUControl[3:2] == 2'b10 ? alu_b << {ALUControl[1:0], 4'b0000} : '0;
    alu_zero = alu_result == '0;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [1:0] op, input logic [10:0] opc, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    bus.req_aluop = op;
    bus.req_opcode = opc;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask
  task automatic run(input string tag, input logic [1:0] op, input logic [10:0] opc, input logic [63:0] a,
                     input logic [63:0] b, input logic [3:0] ctl, input logic [63:0] res, input logic z);
    issue(op, opc, a, b);
    chk({tag, ".ctl"}, ALUControl, ctl);
    chk({tag, ".alu_a"}, alu_a, a);
    chk({tag, ".alu_b"}, alu_b, b);
    chk({tag, ".exec_valid"}, bus.rsp_valid, 0);
    @(posedge clk);
    #1 chk({tag, ".valid"}, bus.rsp_valid, 1);
    chk({tag, ".result"}, bus.rsp_result, res);
    chk({tag, ".zero"}, bus.rsp_zero, z);
    chk({tag, ".illegal"}, bus.rsp_illegal, 0);
    chk({tag, ".idle_ctl"}, ALUControl, 4'hF);
    @(posedge clk);
    #1 chk({tag, ".done_valid"}, bus.rsp_valid, 0);
    chk({tag, ".ready"}, bus.req_ready, 1);
  endtask
  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_aluop = '0;
    bus.req_opcode = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("rst.ready", bus.req_ready, 1);
    chk("rst.valid", bus.rsp_valid, 0);
    chk("rst.result", bus.rsp_result, 0);
    chk("rst.zero", bus.rsp_zero, 0);
    chk("rst.illegal", bus.rsp_illegal, 0);
    chk("rst.ctl", ALUControl, 4'hF);
    chk("rst.alu_a", alu_a, 0);
    chk("rst.alu_b", alu_b, 0);
    chk("rst.count", op_count, 0);
    reset = 1'b0;
    run("sub", 2'b10, 11'b11001011000, 64'd5, 64'd5, 4'b0110, 64'd0, 1'b1);
    chk("sub.count", op_count, 1);
    run("movz", 2'b11, 11'b11010010110, 64'd0, 64'h1234, 4'b1010, 64'h0000_1234_0000_0000, 1'b0);
    chk("movz.count", op_count, 2);
    issue(2'b10, 11'b11111111111, 64'd9, 64'd9);
    chk("ill.valid", bus.rsp_valid, 1);
    chk("ill.illegal", bus.rsp_illegal, 1);
    chk("ill.result", bus.rsp_result, 0);
    chk("ill.zero", bus.rsp_zero, 0);
    chk("ill.ctl", ALUControl, 4'hF);
    @(posedge clk);
    #1 chk("ill.ready", bus.req_ready, 1);
    chk("ill.count", op_count, 2);
    bus.rsp_ready = 1'b0;
    issue(2'b00, 11'b11111000000, 64'd3, 64'd4);
    @(posedge clk);
    #1 bus.req_valid = 1'b1;
    bus.req_aluop = 2'b10;
    bus.req_opcode = 11'b10001010000;
    bus.req_a = 64'hF0F0;
    bus.req_b = 64'hFF00;
    for (int i = 0; i < 5; i++) begin
      chk("stall.valid", bus.rsp_valid, 1);
      chk("stall.result", bus.rsp_result, 64'd7);
      chk("stall.ready", bus.req_ready, 0);
      chk("stall.ctl", ALUControl, 4'hF);
      @(posedge clk);
      #1;
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 chk("b2b.ready", bus.req_ready, 1);
    chk("b2b.valid", bus.rsp_valid, 0);
    chk("b2b.ctl", ALUControl, 4'hF);
    chk("b2b.count", op_count, 3);
    bus.req_valid = 1'b0;
    run("and", 2'b10, 11'b10001010000, 64'hF0F0, 64'hFF00, 4'b0000, 64'hF000, 1'b0);
    run("orr", 2'b10, 11'b10101010000, 64'hF0F0, 64'hFF00, 4'b0001, 64'hFFF0, 1'b0);
    run("cbz", 2'b01, 11'b10110100000, 64'd77, 64'd0, 4'b0111, 64'd0, 1'b1);
    run("add", 2'b10, 11'b10001011000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 4'b0010, 64'd1, 1'b0);
    chk("ops.count", op_count, 7);
    issue(2'b00, 11'b11111000010, 64'd1, 64'd2);
    chk("abort.exec_ctl", ALUControl, 4'b0010);
    reset = 1'b1;
    @(posedge clk);
    #1 chk("abort.valid", bus.rsp_valid, 0);
    chk("abort.ready", bus.req_ready, 1);
    chk("abort.ctl", ALUControl, 4'hF);
    chk("abort.alu_a", alu_a, 0);
    chk("abort.result", bus.rsp_result, 0);
    chk("abort.count", op_count, 0);
    reset = 1'b0;
    @(posedge clk);
    #1 chk("abort.still_idle", bus.rsp_valid, 0);
    @(negedge clk);
    force dut.op_count = 16'hFFFE;
    #1 release dut.op_count;
    run("sat1", 2'b00, 11'd0, 64'd1, 64'd1, 4'b0010, 64'd2, 1'b0);
    chk("sat1.count", op_count, 16'hFFFF);
    run("sat2", 2'b00, 11'd0, 64'd2, 64'd2, 4'b0010, 64'd4, 1'b0);
    chk("sat2.count", op_count, 16'hFFFF);
    run("sat3", 2'b00, 11'd0, 64'd3, 64'd3, 4'b0010, 64'd6, 1'b0);
    chk("sat3.count", op_count, 16'hFFFF);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
